// File: rtl/demux_stream_ctrl_pkg.sv
// Shared types for the packet demux controller: FSM encodings and a small
// helper that maps a destination bit to its locked routing state.
package demux_stream_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROUTE0 = 2'd1,
    ST_ROUTE1 = 2'd2
  } state_t;

  function automatic state_t route_state(input logic dest);
    return dest ? ST_ROUTE1 : ST_ROUTE0;
  endfunction

endpackage

// File: rtl/demux_stream_ctrl_if.sv
// Stream bundle around the demux: one source stream in, two sink streams out.
// Handshake: a word moves on a rising clk edge where valid & ready are both 1;
// a producer holding valid keeps data/last/sel stable until that edge.
interface demux_stream_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_last;

    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out0_last;

    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_last;

    // Environment side: drives the source stream and the sink readies.
    modport master (
        output in_valid, in_data, in_sel, in_last, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out0_last,
               out1_valid, out1_data, out1_last
    );

    // Controller side.
    modport slave (
        input  in_valid, in_data, in_sel, in_last, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out0_last,
               out1_valid, out1_data, out1_last
    );
endinterface

// File: rtl/demux_stream_ctrl_slot.sv
// One-entry output holding register with its own completed-packet counter.
module demux_slot #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    input  logic             ready,
    output logic             can_load,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             last,
    output logic [CNT_W-1:0] pkt_cnt
);
    logic drain;

    assign drain    = valid & ready;
    // A slot that empties on this edge can take the next word on the same edge.
    assign can_load = ~valid | drain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid   <= 1'b0;
            data    <= '0;
            last    <= 1'b0;
            pkt_cnt <= '0;
        end else begin
            if (load) begin
                valid <= 1'b1;
                data  <= load_data;
                last  <= load_last;
            end else if (drain) begin
                valid <= 1'b0;
            end
            // Uses the word leaving now, not one being reloaded on this edge.
            if (drain && last) begin
                pkt_cnt <= pkt_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/demux_stream_ctrl.sv
// Packet-level 1-to-2 demux controller: locks each packet to one output,
// chosen by in_sel or by round-robin, and never splits a packet.
module demux_stream_ctrl
  import demux_stream_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rr_mode,
    demux_stream_ctrl_if.slave  bus,
    output logic [CNT_W-1:0]    pkt_cnt0,
    output logic [CNT_W-1:0]    pkt_cnt1,
    output state_t              state_dbg
);
    state_t state, state_nxt;
    logic   rr_ptr;
    logic   dest;
    logic   accept;
    logic   can0, can1;
    logic   load0, load1;

    always_comb begin
        dest = 1'b0;
        case (state)
            ST_IDLE:   dest = rr_mode ? rr_ptr : bus.in_sel;
            ST_ROUTE0: dest = 1'b0;
            ST_ROUTE1: dest = 1'b1;
            default:   dest = 1'b0;
        endcase
    end

    assign bus.in_ready = ~rst & (dest ? can1 : can0);
    assign accept       = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            rr_ptr <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept && bus.in_last && rr_mode) begin
                rr_ptr <= ~rr_ptr;
            end
        end
    end

    // Only a first beat leaves IDLE; any last beat closes the packet.
    always_comb begin
        state_nxt = state;
        if (state != ST_IDLE && state != ST_ROUTE0 && state != ST_ROUTE1) begin
            state_nxt = ST_IDLE;
        end else if (accept) begin
            if (bus.in_last) begin
                state_nxt = ST_IDLE;
            end else if (state == ST_IDLE) begin
                state_nxt = route_state(dest);
            end
        end
    end

    always_comb begin
        load0     = accept & ~dest;
        load1     = accept & dest;
        state_dbg = state;
    end

    demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot0 (
        .clk       (clk),
        .rst       (rst),
        .load      (load0),
        .load_data (bus.in_data),
        .load_last (bus.in_last),
        .ready     (bus.out0_ready),
        .can_load  (can0),
        .valid     (bus.out0_valid),
        .data      (bus.out0_data),
        .last      (bus.out0_last),
        .pkt_cnt   (pkt_cnt0)
    );

    demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot1 (
        .clk       (clk),
        .rst       (rst),
        .load      (load1),
        .load_data (bus.in_data),
        .load_last (bus.in_last),
        .ready     (bus.out1_ready),
        .can_load  (can1),
        .valid     (bus.out1_valid),
        .data      (bus.out1_data),
        .last      (bus.out1_last),
        .pkt_cnt   (pkt_cnt1)
    );
endmodule

// File: tb/tb_demux_stream_ctrl.sv
// Directed bench for demux_stream_ctrl: routing, round-robin, back-pressure,
// mid-packet reset and counter wrap, with per-output expected-word queues.
module tb_demux_stream_ctrl;
    import demux_stream_ctrl_pkg::*;

    localparam int WIDTH = 8;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic             rr_mode;
    logic [CNT_W-1:0] pkt_cnt0;
    logic [CNT_W-1:0] pkt_cnt1;
    state_t           state_dbg;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] exp0_q[$];
    logic [WIDTH-1:0] exp1_q[$];

    demux_stream_ctrl_if #(.WIDTH(WIDTH)) bus ();

    demux_stream_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .rr_mode   (rr_mode),
        .bus       (bus),
        .pkt_cnt0  (pkt_cnt0),
        .pkt_cnt1  (pkt_cnt1),
        .state_dbg (state_dbg)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic s, input logic l);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_sel   = s;
        bus.in_last  = l;
    endtask

    task automatic pulse_reset;
        rst = 1'b1;
        exp0_q.delete();
        exp1_q.delete();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Scoreboard: every handshake on an output must match the next queued word.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out0_valid && bus.out0_ready) begin
                checks++;
                assert (exp0_q.size() != 0) else begin
                    errors++;
                    $error("FAIL out0_extra observed=%0h expected=none", bus.out0_data);
                end
                if (exp0_q.size() != 0) begin
                    logic [WIDTH-1:0] e0;
                    e0 = exp0_q.pop_front();
                    checks++;
                    assert (bus.out0_data === e0) else begin
                        errors++;
                        $error("FAIL out0_word observed=%0h expected=%0h", bus.out0_data, e0);
                    end
                end
            end
            if (bus.out1_valid && bus.out1_ready) begin
                checks++;
                assert (exp1_q.size() != 0) else begin
                    errors++;
                    $error("FAIL out1_extra observed=%0h expected=none", bus.out1_data);
                end
                if (exp1_q.size() != 0) begin
                    logic [WIDTH-1:0] e1;
                    e1 = exp1_q.pop_front();
                    checks++;
                    assert (bus.out1_data === e1) else begin
                        errors++;
                        $error("FAIL out1_word observed=%0h expected=%0h", bus.out1_data, e1);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        rr_mode = 1'b0;
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);

        // Reset and idle
        tick();
        bus.out0_ready = 1'b1;
        tick();
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out0_valid", bus.out0_valid, 0);
        chk("rst_out1_valid", bus.out1_valid, 0);
        chk("rst_out0_data", bus.out0_data, 0);
        chk("rst_out1_last", bus.out1_last, 0);
        chk("rst_cnt0", pkt_cnt0, 0);
        chk("rst_cnt1", pkt_cnt1, 0);
        chk("rst_state", state_dbg, ST_IDLE);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", bus.in_ready, 1);

        // Select mode: 3-beat packet locked to out1 despite in_sel changes
        bus.out1_ready = 1'b1;
        exp1_q.push_back(8'hA1);
        exp1_q.push_back(8'hA2);
        exp1_q.push_back(8'hA3);
        drive(1'b1, 8'hA1, 1'b1, 1'b0);
        #1;
        chk("sel_in_ready", bus.in_ready, 1);
        tick();
        chk("sel_b1_valid1", bus.out1_valid, 1);
        chk("sel_b1_data1", bus.out1_data, 8'hA1);
        chk("sel_b1_valid0", bus.out0_valid, 0);
        chk("sel_b1_state", state_dbg, ST_ROUTE1);
        drive(1'b1, 8'hA2, 1'b0, 1'b0);
        tick();
        chk("sel_b2_data1", bus.out1_data, 8'hA2);
        chk("sel_b2_valid0", bus.out0_valid, 0);
        drive(1'b1, 8'hA3, 1'b0, 1'b1);
        tick();
        chk("sel_b3_data1", bus.out1_data, 8'hA3);
        chk("sel_b3_last1", bus.out1_last, 1);
        chk("sel_b3_valid0", bus.out0_valid, 0);
        chk("sel_b3_state", state_dbg, ST_IDLE);
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
        chk("sel_drained1", bus.out1_valid, 0);
        chk("sel_cnt1", pkt_cnt1, 1);
        chk("sel_cnt0", pkt_cnt0, 0);

        // Round-robin: single-beat packets alternate out0/out1
        pulse_reset();
        rr_mode = 1'b1;
        exp0_q.push_back(8'h10);
        exp1_q.push_back(8'h11);
        exp0_q.push_back(8'h12);
        exp1_q.push_back(8'h13);
        drive(1'b1, 8'h10, 1'b1, 1'b1);
        tick();
        chk("rr_10_valid0", bus.out0_valid, 1);
        chk("rr_10_data0", bus.out0_data, 8'h10);
        chk("rr_10_valid1", bus.out1_valid, 0);
        drive(1'b1, 8'h11, 1'b0, 1'b1);
        tick();
        chk("rr_11_data1", bus.out1_data, 8'h11);
        chk("rr_11_valid0", bus.out0_valid, 0);
        drive(1'b1, 8'h12, 1'b1, 1'b1);
        tick();
        chk("rr_12_data0", bus.out0_data, 8'h12);
        drive(1'b1, 8'h13, 1'b0, 1'b1);
        tick();
        chk("rr_13_data1", bus.out1_data, 8'h13);
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rr_cnt0", pkt_cnt0, 2);
        chk("rr_cnt1", pkt_cnt1, 2);

        // Back-pressure on out0 with out1 also stalled
        pulse_reset();
        rr_mode = 1'b0;
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        exp0_q.push_back(8'hB1);
        exp0_q.push_back(8'hB2);
        exp0_q.push_back(8'hB3);
        drive(1'b1, 8'hB1, 1'b0, 1'b0);
        #1;
        chk("bp_first_ready", bus.in_ready, 1);
        tick();
        drive(1'b1, 8'hB2, 1'b1, 1'b0);
        #1;
        chk("bp_stall_ready", bus.in_ready, 0);
        tick();
        tick();
        chk("bp_hold_valid", bus.out0_valid, 1);
        chk("bp_hold_data", bus.out0_data, 8'hB1);
        chk("bp_hold_ready", bus.in_ready, 0);
        bus.out0_ready = 1'b1;
        #1;
        chk("bp_resume_ready", bus.in_ready, 1);
        tick();
        chk("bp_b2_data", bus.out0_data, 8'hB2);
        drive(1'b1, 8'hB3, 1'b1, 1'b1);
        tick();
        chk("bp_b3_data", bus.out0_data, 8'hB3);
        chk("bp_b3_last", bus.out0_last, 1);
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
        chk("bp_drained", bus.out0_valid, 0);
        chk("bp_cnt0", pkt_cnt0, 1);
        chk("bp_cnt1", pkt_cnt1, 0);
        chk("bp_out1_idle", bus.out1_valid, 0);

        // Reset after beat 2 of a 4-beat packet to out1
        pulse_reset();
        bus.out1_ready = 1'b1;
        exp1_q.push_back(8'hC1);
        exp1_q.push_back(8'hC2);
        drive(1'b1, 8'hC1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 8'hC2, 1'b0, 1'b0);
        tick();
        chk("mid_pre_state", state_dbg, ST_ROUTE1);
        rst = 1'b1;
        exp0_q.delete();
        exp1_q.delete();
        drive(1'b0, '0, 1'b0, 1'b0);
        #1;
        chk("mid_valid1", bus.out1_valid, 0);
        chk("mid_data1", bus.out1_data, 0);
        chk("mid_in_ready", bus.in_ready, 0);
        chk("mid_state", state_dbg, ST_IDLE);
        chk("mid_cnt1", pkt_cnt1, 0);
        tick();
        rst = 1'b0;
        exp0_q.push_back(8'hD1);
        drive(1'b1, 8'hD1, 1'b0, 1'b1);
        #1;
        chk("mid_new_ready", bus.in_ready, 1);
        tick();
        chk("mid_new_valid0", bus.out0_valid, 1);
        chk("mid_new_data0", bus.out0_data, 8'hD1);
        chk("mid_new_valid1", bus.out1_valid, 0);
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
        chk("mid_new_cnt0", pkt_cnt0, 1);
        chk("mid_new_cnt1", pkt_cnt1, 0);

        // Counter wrap: five packets to out0 with a 2-bit counter
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            exp0_q.push_back(8'hE0 + 8'(i));
            drive(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b1);
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
        chk("wrap_cnt0", pkt_cnt0, 1);
        chk("wrap_cnt1", pkt_cnt1, 0);

        chk("q0_empty", exp0_q.size(), 0);
        chk("q1_empty", exp1_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/demux_stream_ctrl.md
# demux_stream_ctrl

Packet-level controller for the 1-to-2 demultiplexer datapath. It accepts a valid/ready word stream from one source and steers whole packets to one of two sinks. The destination comes from a per-packet select, or from round-robin alternation. Each output has a one-entry holding register, and each output counts completed packets. It sits between a single producer and two consumers, so the same demux can be shared without splitting packets.

## Interface
- WIDTH, 8, data word width
- CNT_W, 8, width of each per-output packet counter
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- rr_mode  input  1  1 = alternate destination per packet and ignore in_sel; 0 = use in_sel
- in_valid  input  1  source word valid
- in_ready  output  1  controller accepts word this cycle
- in_data  input  WIDTH  source word
- in_sel  input  1  destination (0 → out0, 1 → out1); sampled on first beat of a packet only
- in_last  input  1  final beat of packet
- out0_valid / out1_valid  output  1  holding register full
- out0_ready / out1_ready  input  1  sink accepts word
- out0_data / out1_data  output  WIDTH  held word
- out0_last / out1_last  output  1  held word is the final beat
- pkt_cnt0 / pkt_cnt1  output  CNT_W  packets fully delivered on each output

## Operation
- The state machine has three states:
  - IDLE: no packet open.
  - ROUTE0: packet locked to out0.
  - ROUTE1: packet locked to out1.
- Destination dest:
  - In IDLE: rr_mode ? rr_ptr : in_sel.
  - In ROUTEn: n.
- A beat is accepted when in_valid & in_ready.
- in_ready = slot[dest] empty OR (outdest_valid & outdest_ready). A full slot that is draining the same cycle can reload.
- An accepted beat loads {in_data, in_last} into slot[dest] and sets outdest_valid.
- State transitions:
  - IDLE → ROUTEdest on an accepted beat with in_last=0.
  - IDLE stays IDLE on an accepted beat with in_last=1 (single-beat packet).
  - ROUTEn → IDLE on an accepted beat with in_last=1.
- rr_ptr toggles on every accepted beat with in_last=1 while rr_mode=1. Otherwise it holds.
- rr_mode and in_sel changes mid-packet have no effect until the next IDLE first beat.
- outN_valid clears on outN_valid & outN_ready unless the same cycle reloads it.
- pkt_cntN increments on outN_valid & outN_ready & outN_last. It wraps from 2^CNT_W−1 to 0.
- The idle output is never written. A stalled sink on the non-selected output does not block traffic.

## Timing
- Reset values:
  - in_ready = 0 while rst is asserted.
  - all outN_valid, outN_last, outN_data = 0.
  - pkt_cntN = 0, rr_ptr = 0, state = IDLE.
- Latency is one cycle: a word accepted at edge k is presented on its output after edge k.
- Throughput is one word/cycle when the destination sink holds ready=1.
- Back-pressure: with outdest_valid=1 and outdest_ready=0, in_ready=0. The held data is stable until accepted.
- Reset asserted mid-packet clears all state immediately and drops the partial packet. No counter increments for it.
- A counter increments in the cycle after the last-beat handshake is visible on its registered output.

## Structure
- Shared package/header holds the state encodings: ST_IDLE=2'd0, ST_ROUTE0=2'd1, ST_ROUTE1=2'd2.
- Sub-module demux_slot (×2): one-entry holding register with load/drain handshake, data, last and its own packet counter.
- The top level holds the FSM, rr_ptr, dest selection and in_ready mux.

## Test plan
- Reset then idle: all outputs 0 and in_ready=0 during rst. After release with out0_ready=1, in_ready=1.
- rr_mode=0, 3-beat packet A1,A2,A3 with in_sel=1 on beat 1 and in_sel toggled on beats 2–3:
  - all three words appear on out1 on consecutive cycles.
  - out0_valid stays 0.
  - pkt_cnt1=1.
- rr_mode=1, four single-beat packets 0x10..0x13:
  - 0x10 and 0x12 arrive on out0; 0x11 and 0x13 arrive on out1.
  - pkt_cnt0=2, pkt_cnt1=2.
- Back-pressure: hold out0_ready=0 during a packet to out0.
  - in_ready drops after the first beat and data stays stable.
  - Raising out0_ready resumes one word/cycle with no loss or duplication.
  - Meanwhile out1_ready=0 does not affect the packet.
- Reset mid-packet: assert rst after beat 2 of 4.
  - Outputs clear, counters stay 0.
  - The next packet starts fresh in IDLE with its own in_sel.
- Counter wrap with CNT_W=2: deliver 5 single-beat packets to out0 → pkt_cnt0 reads 1.
